// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - parametrised pipeline stage register with valid/ready, stall and flush
// PIPE_REG_SKID_EN selects the 2-entry skid buffer; undefined gives a single-entry stage.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding equals the entry count so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic              main_v;
  logic              skid_v;
  logic              stall_eff;
  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] keep_mask;

  // Flush clears the control LSBs so a killed instruction can never commit.
  for (genvar i = 0; i < DATA_W; i++) begin : g_keep_mask
    assign keep_mask[i] = (i >= CTRL_W);
  end

  assign stall_eff = stall & ~flush;
  assign main_v    = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_v & out_ready & ~stall_eff & ~flush;

  assign out_valid = main_v;
  assign out_data  = main_d;
  assign occupancy = state;

`ifdef PIPE_REG_SKID_EN
  logic [DATA_W-1:0] skid_d;

  assign skid_v   = (state == FULL);
  assign in_ready = rst_n & ~flush & ~stall_eff & ~skid_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_d <= main_d & keep_mask;
      skid_d <= skid_d & keep_mask;
    end else if (!stall_eff) begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= ONE;
            main_d <= in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d <= in_data;
          end else if (in_fire) begin
            state  <= FULL;
            skid_d <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state  <= ONE;
            main_d <= skid_d;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
`else
  assign skid_v   = 1'b0;
  assign in_ready = rst_n & ~flush & ~stall_eff & (~main_v | out_ready);

  // With one entry, an accept while ONE always coincides with a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_d <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_d <= main_d & keep_mask;
    end else if (!stall_eff) begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= ONE;
            main_d <= in_data;
          end
        end
        ONE: begin
          if (in_fire) begin
            main_d <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
`endif

endmodule
